// File: rtl/idex_pipe_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs and execute-side outputs.
// master drives the decode fields; slave is the register itself.
interface idex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 8,
    parameter int WB_W   = 3,
    parameter int M_W    = 3
);
    logic              stall_IDEX;
    logic              flush_IDEX;
    logic              validIn_IDEX;
    logic [DATA_W-1:0] data1In_IDEX;
    logic [DATA_W-1:0] data2In_IDEX;
    logic [DATA_W-1:0] immIn_IDEX;
    logic [REG_W-1:0]  rsIn_IDEX;
    logic [REG_W-1:0]  rtIn_IDEX;
    logic [REG_W-1:0]  rdIn_IDEX;
    logic [PC_W-1:0]   pcIn_IDEX;
    logic [WB_W-1:0]   wbIn_IDEX;
    logic [M_W-1:0]    mIn_IDEX;
    logic [2:0]        exIn_IDEX;

    logic [DATA_W-1:0] data1Out_IDEX;
    logic [DATA_W-1:0] data2Out_IDEX;
    logic [DATA_W-1:0] immOut_IDEX;
    logic [REG_W-1:0]  rsOut_IDEX;
    logic [REG_W-1:0]  rtOut_IDEX;
    logic [REG_W-1:0]  rdOut_IDEX;
    logic [PC_W-1:0]   pcOut_IDEX;
    logic [WB_W-1:0]   wbOut_IDEX;
    logic [M_W-1:0]    mOut_IDEX;
    logic              ALUSrc_IDEX;
    logic              ALUOp_IDEX;
    logic              RegDst_IDEX;
    logic              validOut_IDEX;
    logic              hazard_IDEX;

    modport master (
        output stall_IDEX, flush_IDEX, validIn_IDEX,
        output data1In_IDEX, data2In_IDEX, immIn_IDEX,
        output rsIn_IDEX, rtIn_IDEX, rdIn_IDEX,
        output pcIn_IDEX, wbIn_IDEX, mIn_IDEX, exIn_IDEX,
        input  data1Out_IDEX, data2Out_IDEX, immOut_IDEX,
        input  rsOut_IDEX, rtOut_IDEX, rdOut_IDEX,
        input  pcOut_IDEX, wbOut_IDEX, mOut_IDEX,
        input  ALUSrc_IDEX, ALUOp_IDEX, RegDst_IDEX,
        input  validOut_IDEX, hazard_IDEX
    );

    modport slave (
        input  stall_IDEX, flush_IDEX, validIn_IDEX,
        input  data1In_IDEX, data2In_IDEX, immIn_IDEX,
        input  rsIn_IDEX, rtIn_IDEX, rdIn_IDEX,
        input  pcIn_IDEX, wbIn_IDEX, mIn_IDEX, exIn_IDEX,
        output data1Out_IDEX, data2Out_IDEX, immOut_IDEX,
        output rsOut_IDEX, rtOut_IDEX, rdOut_IDEX,
        output pcOut_IDEX, wbOut_IDEX, mOut_IDEX,
        output ALUSrc_IDEX, ALUOp_IDEX, RegDst_IDEX,
        output validOut_IDEX, hazard_IDEX
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with stall, flush bubble and valid bit.
// Define IDEX_HAZARD_EN to build the internal load-use hazard detector.
module idex_pipe_reg #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int PC_W      = 8,
    parameter int WB_W      = 3,
    parameter int M_W       = 3,
    parameter int MEMRD_BIT = 1
) (
    input  logic          clk_IDEX,
    input  logic          rst_IDEX,
    idex_pipe_reg_if.slave bus
);
    logic [DATA_W-1:0] d1_q, d2_q, imm_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [PC_W-1:0]   pc_q;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    logic [2:0]        ex_q;
    logic              valid_q;
    logic              hazard;
    logic              bubble;
    logic              hold;

`ifdef IDEX_HAZARD_EN
    logic rt_match;
    assign rt_match = (rt_q == bus.rsIn_IDEX) | (rt_q == bus.rtIn_IDEX);
    assign hazard = valid_q & m_q[MEMRD_BIT] & (rt_q != '0)
                  & bus.validIn_IDEX & rt_match;
`else
    assign hazard = 1'b0;
`endif

    // flush outranks stall; a hazard only bubbles when not stalled
    assign bubble = bus.flush_IDEX | (~bus.stall_IDEX & hazard);
    assign hold   = ~bus.flush_IDEX & bus.stall_IDEX;

    always_ff @(posedge clk_IDEX) begin
        if (rst_IDEX) begin
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            d1_q  <= bus.data1In_IDEX;
            d2_q  <= bus.data2In_IDEX;
            imm_q <= bus.immIn_IDEX;
            rs_q  <= bus.rsIn_IDEX;
            rt_q  <= bus.rtIn_IDEX;
            rd_q  <= bus.rdIn_IDEX;
            pc_q  <= bus.pcIn_IDEX;
            if (bubble) begin
                wb_q    <= '0;
                m_q     <= '0;
                ex_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                wb_q    <= bus.wbIn_IDEX;
                m_q     <= bus.mIn_IDEX;
                ex_q    <= bus.exIn_IDEX;
                valid_q <= bus.validIn_IDEX;
            end
        end
    end

    assign bus.data1Out_IDEX = d1_q;
    assign bus.data2Out_IDEX = d2_q;
    assign bus.immOut_IDEX   = imm_q;
    assign bus.rsOut_IDEX    = rs_q;
    assign bus.rtOut_IDEX    = rt_q;
    assign bus.rdOut_IDEX    = rd_q;
    assign bus.pcOut_IDEX    = pc_q;
    assign bus.wbOut_IDEX    = wb_q;
    assign bus.mOut_IDEX     = m_q;
    assign bus.ALUSrc_IDEX   = ex_q[0];
    assign bus.ALUOp_IDEX    = ex_q[1];
    assign bus.RegDst_IDEX   = ex_q[2];
    assign bus.validOut_IDEX = valid_q;
    assign bus.hazard_IDEX   = hazard;
endmodule
